// File: rtl/axi_csr_pkg.sv
// Shared definitions for the AXI4-Lite CSR bank.
// Contents: register offsets, channel window base/stride, AXI response codes,
// write/read FSM state enums, the address decoder and a byte-strobe merge helper.
package axi_csr_pkg;

   // Global registers (offsets within the first 16-byte window)
   localparam logic [3:0] REG_ID         = 4'h0;
   localparam logic [3:0] REG_IRQ_STATUS = 4'h4;
   localparam logic [3:0] REG_IRQ_ENABLE = 4'h8;

   // Per-channel registers (offsets within each channel window)
   localparam logic [3:0] CH_CTRL      = 4'h0;
   localparam logic [3:0] CH_STATUS    = 4'h4;
   localparam logic [3:0] CH_PIXEL_CNT = 4'h8;
   localparam logic [3:0] CH_QUANT     = 4'hC;

   localparam int unsigned CH_BASE   = 32'h10;
   localparam int unsigned CH_STRIDE = 32'h10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   typedef struct packed {
      logic       hit;    // address maps to a register
      logic       is_ch;  // channel window (else global window)
      logic [2:0] ch;     // channel index, valid when is_ch
      logic [3:0] off;    // word-aligned offset inside the window
   } dec_t;

   // Address bits [1:0] are ignored; 0x0C in the global window is a hole.
   function automatic dec_t decode(input logic [31:0] addr, input int unsigned num_ch);
      dec_t        d;
      int unsigned idx;
      d.off   = {addr[3:2], 2'b00};
      d.hit   = 1'b0;
      d.is_ch = 1'b0;
      d.ch    = '0;
      if (addr < CH_BASE) begin
         d.hit = (d.off != 4'hC);
      end else begin
         idx     = (addr - CH_BASE) / CH_STRIDE;
         d.is_ch = 1'b1;
         d.hit   = (idx < num_ch);
         d.ch    = 3'(idx);
      end
      return d;
   endfunction

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[b*8 +: 8] = strb[b] ? data[b*8 +: 8] : old_val[b*8 +: 8];
      return r;
   endfunction

endpackage

// File: rtl/axi_csr_irq_ctrl.sv
// Per-channel interrupt logic.
// Ports: clk/rst; done (raw per-channel done levels), enable (IRQ_ENABLE bits),
// clear (one-cycle clear requests on the write commit edge);
// done_sync (done delayed one flop), pending (sticky flags), irq (registered
// OR of pending & enable).
module axi_csr_irq_ctrl #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] done,
   input  logic [N-1:0] enable,
   input  logic [N-1:0] clear,
   output logic [N-1:0] done_sync,
   output logic [N-1:0] pending,
   output logic         irq
);

   logic [N-1:0] done_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         done_sync <= '0;
         done_prev <= '0;
         pending   <= '0;
         irq       <= 1'b0;
      end else begin
         done_sync <= done;
         done_prev <= done_sync;
         // A rising edge of the synchronised done wins over a same-cycle clear.
         pending   <= (pending & ~clear) | (done_sync & ~done_prev);
         irq       <= |(pending & enable);
      end
   end

endmodule

// File: rtl/axi_lite_csr_bank.sv
// AXI4-Lite CSR bank serving NUM_CH pixel-processing channels.
// Ports: AXI4-Lite slave (aw/w/b/ar/r channels) on clk with synchronous rst;
// per-channel o_start / o_clear_irq pulses, o_num_pixels and o_quant_mode
// fields, i_done level inputs and the o_irq interrupt output.
module axi_lite_csr_bank
   import axi_csr_pkg::*;
#(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 8,
   parameter int          NUM_CH     = 4,
   parameter int          PIX_WIDTH  = 16,
   parameter logic [31:0] VERSION    = 32'h0002_0000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_WIDTH-1:0]       aw_addr,
   input  logic                        aw_valid,
   output logic                        aw_ready,
   input  logic [DATA_WIDTH-1:0]       w_data,
   input  logic [DATA_WIDTH/8-1:0]     w_strb,
   input  logic                        w_valid,
   output logic                        w_ready,
   output logic [1:0]                  b_resp,
   output logic                        b_valid,
   input  logic                        b_ready,
   input  logic [ADDR_WIDTH-1:0]       ar_addr,
   input  logic                        ar_valid,
   output logic                        ar_ready,
   output logic [DATA_WIDTH-1:0]       r_data,
   output logic [1:0]                  r_resp,
   output logic                        r_valid,
   input  logic                        r_ready,
   output logic [NUM_CH-1:0]           o_start,
   output logic [NUM_CH-1:0]           o_clear_irq,
   output logic [NUM_CH*PIX_WIDTH-1:0] o_num_pixels,
   output logic [NUM_CH*2-1:0]         o_quant_mode,
   input  logic [NUM_CH-1:0]           i_done,
   output logic                        o_irq
);

   w_state_t w_state, w_next;
   r_state_t r_state, r_next;

   logic                  ready_en;   // low during reset, high from the first edge after it
   logic                  aw_held, w_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [31:0]           w_data_q;
   logic [3:0]            w_strb_q;
   logic                  aw_hs, w_hs, ar_hs, commit;
   logic [ADDR_WIDTH-1:0] wa;
   logic [31:0]           wd;
   logic [3:0]            ws;
   dec_t                  wr_dec, rd_dec;
   logic                  glob_w, en_we, w1c_we;
   logic [NUM_CH-1:0]     irq_enable, clr, pending, done_sync;
   logic [NUM_CH*30-1:0]  ctrl_flat;
   logic [31:0]           rd_val;

   always_ff @(posedge clk) begin
      if (rst) ready_en <= 1'b0;
      else     ready_en <= 1'b1;
   end

   // ---------------- write path ----------------
   assign aw_hs  = aw_valid & aw_ready;
   assign w_hs   = w_valid & w_ready;
   // Commit on the edge where the second of AW/W arrives (or both together).
   assign commit = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);
   assign wa     = aw_held ? aw_addr_q : aw_addr;
   assign wd     = w_held  ? w_data_q  : w_data;
   assign ws     = w_held  ? w_strb_q  : w_strb;
   assign wr_dec = decode(32'(wa), NUM_CH);
   assign glob_w = commit & wr_dec.hit & ~wr_dec.is_ch;
   assign en_we  = glob_w & (wr_dec.off == REG_IRQ_ENABLE) & ws[0];
   assign w1c_we = glob_w & (wr_dec.off == REG_IRQ_STATUS) & ws[0];

   always_ff @(posedge clk) begin
      if (rst) w_state <= W_IDLE;
      else     w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (commit)  w_next = W_RESP;
         W_RESP:  if (b_ready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      aw_ready = ready_en & ~rst & (w_state == W_IDLE) & ~aw_held;
      w_ready  = ready_en & ~rst & (w_state == W_IDLE) & ~w_held;
      b_valid  = (w_state == W_RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held    <= 1'b0;
         w_held     <= 1'b0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         b_resp     <= RESP_OKAY;
         irq_enable <= '0;
      end else begin
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            b_resp  <= wr_dec.hit ? RESP_OKAY : RESP_SLVERR;
         end else begin
            if (aw_hs) begin
               aw_held   <= 1'b1;
               aw_addr_q <= aw_addr;
            end
            if (w_hs) begin
               w_held   <= 1'b1;
               w_data_q <= w_data;
               w_strb_q <= w_strb;
            end
         end
         if (en_we) irq_enable <= wd[NUM_CH-1:0];
      end
   end

   // ---------------- per-channel registers ----------------
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                 sel, ctrl_we, pulse_ok;
      logic [29:0]          ctrl_q;
      logic [PIX_WIDTH-1:0] pix_q;
      logic [1:0]           quant_q;
      logic                 start_q, clr_q;
      logic [31:0]          ctrl_m, pix_m;

      assign sel      = commit & wr_dec.hit & wr_dec.is_ch & (wr_dec.ch == 3'(gi));
      assign ctrl_we  = sel & (wr_dec.off == CH_CTRL);
      assign pulse_ok = ctrl_we & ws[0];
      assign ctrl_m   = apply_strb({ctrl_q, 2'b00}, wd, ws);
      assign pix_m    = apply_strb(32'(pix_q), wd, ws);
      assign clr[gi]  = (pulse_ok & wd[1]) | (w1c_we & wd[gi]);

      always_ff @(posedge clk) begin
         if (rst) begin
            ctrl_q  <= '0;
            pix_q   <= '0;
            quant_q <= '0;
            start_q <= 1'b0;
            clr_q   <= 1'b0;
         end else begin
            if (ctrl_we) ctrl_q <= ctrl_m[31:2];
            if (sel && wr_dec.off == CH_PIXEL_CNT) pix_q <= PIX_WIDTH'(pix_m);
            if (sel && wr_dec.off == CH_QUANT && ws[0]) quant_q <= wd[1:0];
            start_q <= pulse_ok & wd[0];
            clr_q   <= pulse_ok & wd[1];
         end
      end

      assign o_start[gi]                              = start_q;
      assign o_clear_irq[gi]                          = clr_q;
      assign o_num_pixels[gi*PIX_WIDTH +: PIX_WIDTH]  = pix_q;
      assign o_quant_mode[gi*2 +: 2]                  = quant_q;
      assign ctrl_flat[gi*30 +: 30]                   = ctrl_q;
   end

   axi_csr_irq_ctrl #(.N(NUM_CH)) u_irq (
      .clk       (clk),
      .rst       (rst),
      .done      (i_done),
      .enable    (irq_enable),
      .clear     (clr),
      .done_sync (done_sync),
      .pending   (pending),
      .irq       (o_irq)
   );

   // ---------------- read path ----------------
   assign ar_hs  = ar_valid & ar_ready;
   assign rd_dec = decode(32'(ar_addr), NUM_CH);

   always_comb begin
      rd_val = '0;
      if (rd_dec.hit && !rd_dec.is_ch) begin
         case (rd_dec.off)
            REG_ID:         rd_val = VERSION;
            REG_IRQ_STATUS: rd_val = 32'(pending);
            REG_IRQ_ENABLE: rd_val = 32'(irq_enable);
            default:        rd_val = '0;
         endcase
      end else if (rd_dec.hit) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (rd_dec.ch == 3'(c)) begin
               case (rd_dec.off)
                  CH_CTRL:      rd_val = {ctrl_flat[c*30 +: 30], 2'b00};
                  CH_STATUS:    rd_val = {30'b0, pending[c], done_sync[c]};
                  CH_PIXEL_CNT: rd_val = 32'(o_num_pixels[c*PIX_WIDTH +: PIX_WIDTH]);
                  default:      rd_val = {30'b0, o_quant_mode[c*2 +: 2]};
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs)   r_next = R_DATA;
         R_DATA:  if (r_ready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      ar_ready = ready_en & ~rst & (r_state == R_IDLE);
      r_valid  = (r_state == R_DATA);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= '0;
         r_resp <= RESP_OKAY;
      end else if (ar_hs) begin
         r_data <= rd_val;
         r_resp <= rd_dec.hit ? RESP_OKAY : RESP_SLVERR;
      end
   end

endmodule

// File: tb/tb_axi_lite_csr_bank.sv
module tb_axi_lite_csr_bank;

   localparam logic [31:0] VER = 32'h0002_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  aw_addr, ar_addr;
   logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
   logic        ar_valid, ar_ready, r_valid, r_ready;
   logic [31:0] w_data, r_data;
   logic [3:0]  w_strb;
   logic [1:0]  b_resp, r_resp;
   logic [3:0]  o_start, o_clear_irq, i_done;
   logic [63:0] o_num_pixels;
   logic [7:0]  o_quant_mode;
   logic        o_irq;

   axi_lite_csr_bank dut (
      .clk(clk), .rst(rst),
      .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
      .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
      .o_start(o_start), .o_clear_irq(o_clear_irq), .o_num_pixels(o_num_pixels),
      .o_quant_mode(o_quant_mode), .i_done(i_done), .o_irq(o_irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [31:0] d; logic [1:0] r; } rexp_t;
   logic [1:0] bq[$];
   rexp_t      rq[$];

   // Reference model of the register file
   logic [31:0] m_ctrl[4];
   logic [15:0] m_pix[4];
   logic [1:0]  m_quant[4];
   logic [3:0]  m_en, m_pend;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=no-handshake required=handshake", name);
   endtask

   function automatic logic [31:0] strb_mask(input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
      return m;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] addr, output logic [1:0] resp);
      int a, c;
      a = int'(addr) & 32'hFC;
      resp = 2'b00;
      if (a == 0) return VER;
      if (a == 4) return 32'(m_pend);
      if (a == 8) return 32'(m_en);
      c = (a - 16) / 16;
      if (a == 12 || c >= 4) begin resp = 2'b10; return 0; end
      case (a % 16)
         0:       return m_ctrl[c];
         4:       return {30'b0, m_pend[c], i_done[c]};
         8:       return 32'(m_pix[c]);
         default: return 32'(m_quant[c]);
      endcase
   endfunction

   function automatic void model_write(input logic [7:0] addr, input logic [31:0] d,
                                       input logic [3:0] s, output logic [1:0] resp,
                                       output logic [3:0] st, output logic [3:0] cl);
      int a, c;
      logic [31:0] m;
      a = int'(addr) & 32'hFC;
      m = strb_mask(s);
      resp = 2'b00; st = 0; cl = 0;
      c = (a - 16) / 16;
      if (a == 4) begin
         if (s[0]) m_pend = m_pend & ~d[3:0];
      end else if (a == 8) begin
         if (s[0]) m_en = d[3:0];
      end else if (a == 12 || (a >= 16 && c >= 4)) begin
         resp = 2'b10;
      end else if (a >= 16) begin
         case (a % 16)
            0: begin
               m_ctrl[c] = ((m_ctrl[c] & ~m) | (d & m)) & 32'hFFFF_FFFC;
               if (s[0]) begin
                  st[c] = d[0];
                  cl[c] = d[1];
                  if (d[1]) m_pend[c] = 1'b0;
               end
            end
            8:  m_pix[c] = 16'(({16'b0, m_pix[c]} & ~m) | (d & m));
            12: if (s[0]) m_quant[c] = d[1:0];
            default: ;
         endcase
      end
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int hold);
      logic [1:0] er;
      logic [3:0] est, ecl;
      bit aw_done, w_done, awh, wh, got;
      int t;
      model_write(addr, data, strb, er, est, ecl);
      bq.push_back(er);
      aw_addr = addr; w_data = data; w_strb = strb;
      aw_done = 0; w_done = 0; t = 0;
      while (!(aw_done && w_done) && t < 50) begin
         aw_valid = !aw_done && t >= aw_dly;
         w_valid  = !w_done && t >= w_dly;
         awh = aw_valid && aw_ready;
         wh  = w_valid && w_ready;
         @(posedge clk); #1;
         if (awh) aw_done = 1;
         if (wh) w_done = 1;
         t++;
      end
      aw_valid = 0; w_valid = 0;
      if (!(aw_done && w_done)) begin timeout("aw_w_handshake"); return; end
      chk("start_pulse", o_start, est);
      chk("clear_pulse", o_clear_irq, ecl);
      for (int i = 0; i < hold; i++) begin
         chk("b_hold_valid", b_valid, 1);
         chk("b_hold_aw_ready", aw_ready, 0);
         chk("b_hold_w_ready", w_ready, 0);
         step(1);
         if (i == 0) chk("pulses_one_cycle", {o_start, o_clear_irq}, 0);
      end
      b_ready = 1; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         got = b_valid;
         step(1);
         if (hold == 0 && i == 0) chk("pulses_one_cycle", {o_start, o_clear_irq}, 0);
      end
      b_ready = 0;
      if (!got) timeout("b_handshake");
      chk("num_pixels", o_num_pixels, {m_pix[3], m_pix[2], m_pix[1], m_pix[0]});
      chk("quant_mode", o_quant_mode, {m_quant[3], m_quant[2], m_quant[1], m_quant[0]});
      chk("irq_level", o_irq, |(m_pend & m_en));
   endtask

   task automatic axi_read(input logic [7:0] addr);
      rexp_t e;
      logic [1:0] r;
      bit hs, got;
      e.d = model_read(addr, r);
      e.r = r;
      rq.push_back(e);
      ar_addr = addr; ar_valid = 1; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         hs = ar_ready;
         step(1);
         got = hs;
      end
      ar_valid = 0;
      if (!got) begin timeout("ar_handshake"); return; end
      chk("r_latency", r_valid, 1);
      r_ready = 1; got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         got = r_valid;
         step(1);
      end
      r_ready = 0;
      if (!got) timeout("r_handshake");
   endtask

   // Scoreboard monitor: compares every response handshake against the queues
   logic [1:0] mon_b;
   rexp_t      mon_r;
   always @(negedge clk) begin
      if (!rst && b_valid && b_ready) begin
         if (bq.size() == 0) timeout("b_unexpected");
         else begin
            mon_b = bq.pop_front();
            $display("write response resp=%0d expected=%0d", b_resp, mon_b);
            chk("b_resp", b_resp, mon_b);
         end
      end
      if (!rst && r_valid && r_ready) begin
         if (rq.size() == 0) timeout("r_unexpected");
         else begin
            mon_r = rq.pop_front();
            $display("read response data=%h resp=%0d expected=%h/%0d", r_data, r_resp, mon_r.d, mon_r.r);
            chk("r_data", r_data, mon_r.d);
            chk("r_resp", r_resp, mon_r.r);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] a;
      rst = 1; aw_addr = 0; ar_addr = 0; aw_valid = 0; w_valid = 0; ar_valid = 0;
      w_data = 0; w_strb = 0; b_ready = 0; r_ready = 0; i_done = 0;
      for (int c = 0; c < 4; c++) begin m_ctrl[c] = 0; m_pix[c] = 0; m_quant[c] = 0; end
      m_en = 0; m_pend = 0;

      // Reset state
      step(3);
      chk("rst_aw_ready", aw_ready, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_ar_ready", ar_ready, 0);
      chk("rst_valids", {b_valid, r_valid}, 0);
      chk("rst_outputs", {o_num_pixels, o_quant_mode, o_start, o_clear_irq, o_irq}, 0);
      chk("rst_r_data", r_data, 0);
      rst = 0;
      step(1);
      chk("post_rst_readies", {aw_ready, w_ready, ar_ready}, 3'b111);

      axi_read(8'h00);
      axi_read(8'h18);

      // W leads AW by 3 cycles, then a partial-strobe overwrite
      axi_write(8'h28, 32'h0000_1234, 4'b0011, 3, 0, 0);
      chk("ch1_pix_first", o_num_pixels[31:16], 16'h1234);
      axi_write(8'h28, 32'hFFFF_FF00, 4'b0010, 0, 0, 0);
      chk("ch1_pix_merged", o_num_pixels[31:16], 16'hFF34);
      axi_read(8'h28);

      // CTRL start + clear pulses on channel 2
      axi_write(8'h30, 32'h3, 4'b1111, 1, 0, 0);
      axi_read(8'h30);

      // Interrupt path
      axi_write(8'h08, 32'h1, 4'b0001, 0, 0, 0);
      i_done[0] = 1'b1;
      step(2);
      chk("irq_before_3cyc", o_irq, 0);
      step(1);
      chk("irq_after_3cyc", o_irq, 1);
      m_pend[0] = 1'b1;
      axi_read(8'h04);
      axi_read(8'h14);
      axi_write(8'h04, 32'h1, 4'b0001, 0, 2, 0);
      step(5);
      chk("irq_cleared_done_high", o_irq, 0);
      axi_read(8'h04);
      i_done = 0;
      step(3);

      // Unmapped
      axi_write(8'h7C, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0);
      axi_read(8'h7C);

      // Held write response with a concurrent read
      fork
         axi_write(8'h4C, 32'h2, 4'b0001, 0, 0, 5);
         begin
            step(2);
            axi_read(8'h00);
         end
      join

      // Randomized traffic against the model
      for (int n = 0; n < 80; n++) begin
         a = 8'($urandom_range(0, 127));
         if ($urandom_range(0, 1) == 1)
            axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         else
            axi_read(a);
      end

      step(3);
      chk("queues_drained", {32'(bq.size()), 32'(rq.size())}, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
